// File: rtl/bit_counter_pkg.sv
// Shared types and default sizes for the bit-counter arbiter slice.
package bit_counter_pkg;

  // Default sizes; the arbiter's parameters default to these.
  localparam int N_REQ_DEF     = 4;
  localparam int A_WIDTH_DEF   = 8;
  localparam int RET_WIDTH_DEF = 4;

  // Controller states for the shared-counter handshake.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    ACK     = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_width(N_REQ_DEF);

endpackage

// File: rtl/bit_counter_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping from N_REQ-1 back to 0. Holds no state of its own.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // cand[k] is the requester index sitting k places after the pointer.
  logic [IDX_W-1:0] cand [N_REQ];
  logic [N_REQ-1:0] hit;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      // One extra bit so ptr+offset cannot overflow before the wrap.
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum >= (IDX_W+1)'(N_REQ))
                      ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                      : sum[IDX_W-1:0];
      assign hit[gi] = req[cand[gi]];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/bit_counter_arbiter.sv
// Shares one bit_counter between N_REQ clients. Grants round-robin,
// latches the winner's operand, runs the counter's s/A/done handshake and
// returns the count to the winner with a single-cycle ack pulse.
module bit_counter_arbiter
  import bit_counter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int A_WIDTH   = A_WIDTH_DEF,
  parameter int RET_WIDTH = RET_WIDTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*A_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [RET_WIDTH-1:0]       result,
  output logic                       busy,
  output logic                       bc_s,
  output logic [A_WIDTH-1:0]         bc_A,
  input  logic                       bc_done,
  input  logic [RET_WIDTH-1:0]       bc_result
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_t           state_reg;
  arb_state_t           state_next;
  logic [IDX_W-1:0]     ptr_reg;
  logic [IDX_W-1:0]     winner_reg;
  logic [A_WIDTH-1:0]   a_reg;
  logic [RET_WIDTH-1:0] result_reg;

  logic                 grant_take;
  logic                 result_take;
  logic                 ptr_adv;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;

  // Operand of each requester, unpacked from the flat bus.
  logic [A_WIDTH-1:0]   req_ops [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ops
      assign req_ops[gi] = req_data[gi*A_WIDTH +: A_WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req         (req),
    .ptr         (ptr_reg),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // State register; reset abandons any job in flight without an ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture winner and its operand only on the grant edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg      <= '0;
      winner_reg <= '0;
    end else if (grant_take) begin
      a_reg      <= req_ops[grant_idx];
      winner_reg <= grant_idx;
    end
  end

  // Result is captured when done is first seen and held between jobs.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_reg <= '0;
    end else if (result_take) begin
      result_reg <= bc_result;
    end
  end

  // Round-robin pointer moves past the winner once its job is acked.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (ptr_adv) begin
      ptr_reg <= (winner_reg == IDX_W'(N_REQ - 1)) ? '0
                                                  : winner_reg + IDX_W'(1);
    end
  end

  // Next-state and handshake outputs; bc_s is only ever high in RUN so the
  // counter drops back to its idle whenever the job ends or is aborted.
  always_comb begin
    state_next  = state_reg;
    grant_take  = 1'b0;
    result_take = 1'b0;
    ptr_adv     = 1'b0;
    bc_s        = 1'b0;
    busy        = 1'b1;
    ack         = '0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (grant_valid) begin
          grant_take = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        // Counter is idle here and loads bc_A; done is deliberately ignored.
        state_next = RUN;
      end
      RUN: begin
        bc_s = 1'b1;
        if (bc_done) begin
          result_take = 1'b1;
          state_next  = ACK;
        end
      end
      ACK: begin
        ack[winner_reg] = 1'b1;
        ptr_adv         = 1'b1;
        state_next      = RELEASE;
      end
      RELEASE: begin
        // Wait for the counter to withdraw done before the next grant.
        if (!bc_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bc_A   = a_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_bit_counter_arbiter.sv
// Self-checking bench: a job-level reference model plus a bit_counter
// responder, with directed scenarios followed by randomized traffic.
module tb_bit_counter_arbiter;

  localparam int N = 4;

  logic         clock;
  logic         reset;
  logic [3:0]   req;
  logic [31:0]  req_data;
  logic [3:0]   ack;
  logic [3:0]   result;
  logic         busy;
  logic         bc_s;
  logic [7:0]   bc_A;
  logic         bc_done;
  logic [3:0]   bc_result;

  int n_checks = 0;
  int n_err    = 0;

  bit_counter_arbiter #(.N_REQ(4), .A_WIDTH(8), .RET_WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .result    (result),
    .busy      (busy),
    .bc_s      (bc_s),
    .bc_A      (bc_A),
    .bc_done   (bc_done),
    .bc_result (bc_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks one job at a time in terms of grant, counting,
  // ack and waiting for done to clear.
  bit         m_armed  = 0;
  int         m_ptr    = 0;
  bit         m_job    = 0;
  bit         m_run    = 0;
  bit         m_ack    = 0;
  bit         m_rel    = 0;
  int         m_idx    = 0;
  logic [7:0] m_op     = '0;
  logic [7:0] m_bcA    = '0;
  logic [3:0] m_result = '0;

  always @(posedge clock) begin
    int c;
    if (reset) begin
      m_armed = 1; m_ptr = 0; m_job = 0; m_run = 0; m_ack = 0; m_rel = 0;
      m_idx = 0; m_op = '0; m_bcA = '0; m_result = '0;
    end else if (m_armed) begin
      if (m_ack) begin
        m_ack = 0; m_job = 0; m_rel = 1;
        m_ptr = (m_idx + 1) % N;
      end else if (m_rel) begin
        if (!bc_done) m_rel = 0;
      end else if (m_run) begin
        if (bc_done) begin
          m_run = 0; m_ack = 1;
          m_result = 4'($countones(m_op));
        end
      end else if (m_job) begin
        m_run = 1;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (req[c] && !m_job) begin
            m_job = 1; m_idx = c;
            m_op = req_data[c*8 +: 8];
            m_bcA = m_op;
          end
        end
      end
    end
  end

  // Responder configuration (directed mode) and state.
  bit rand_mode = 0;
  int delay_cfg = 1;
  int hold_cfg  = 0;
  int resp_cnt  = 0;
  bit resp_started = 0;
  int hold_cnt  = 0;

  // Compare DUT against the model, then advance the bit_counter responder.
  always @(negedge clock) begin
    logic [3:0] exp_ack;
    if (m_armed) begin
      exp_ack = m_ack ? 4'(1 << m_idx) : 4'b0;
      check("ack",    32'(ack),    32'(exp_ack));
      check("busy",   32'(busy),   32'(m_job || m_rel));
      check("bc_s",   32'(bc_s),   32'(m_run));
      check("bc_A",   32'(bc_A),   32'(m_bcA));
      check("result", 32'(result), 32'(m_result));
      if (|ack) begin
        for (int i = 0; i < N; i++)
          if (ack[i]) $display("ack req=%0d result=%0d t=%0t", i, result, $time);
      end
    end
    if (reset) begin
      bc_done = 1'b0; resp_started = 0; hold_cnt = 0;
    end else if (!bc_s) begin
      resp_started = 0;
      if (bc_done && hold_cnt > 0) hold_cnt--;
      else bc_done = 1'b0;
    end else if (!bc_done) begin
      if (!resp_started) begin
        resp_started = 1;
        resp_cnt = rand_mode ? ((bc_A == 0) ? 0 : int'($urandom_range(0, 4)))
                             : delay_cfg;
      end
      if (resp_cnt == 0) begin
        bc_done   = 1'b1;
        bc_result = 4'($countones(bc_A));
        hold_cnt  = rand_mode ? int'($urandom_range(0, 2)) : hold_cfg;
      end else begin
        resp_cnt--;
      end
    end
  end

  task automatic set_op(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Cycles until bc_s is seen high; returns the budget on timeout.
  task automatic wait_bcs(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (bc_s) break;
    end
  endtask

  // First ack pulse within the budget; zeros on timeout.
  task automatic wait_ack(output logic [3:0] a, output logic [3:0] r);
    a = '0; r = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (|ack) begin
        a = ack; r = result;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] a, r;
    logic [7:0] ops [4];
    logic [3:0] pend;
    int lat, expi;

    reset = 1'b1; req = '0; req_data = '0;
    bc_done = 1'b0; bc_result = '0;
    repeat (3) @(negedge clock);
    check("rst_ack",    32'(ack),    32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_bc_s",   32'(bc_s),   32'h0);
    check("rst_bc_A",   32'(bc_A),   32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Single request on requester 2.
    delay_cfg = 1;
    set_op(2, 8'hB5);
    req = 4'b0100;
    wait_bcs(lat);
    check("t1_latency", 32'(lat), 32'd2);
    wait_ack(a, r);
    check("t1_ack", 32'(a), 32'h4);
    check("t1_result", 32'(r), 32'd5);
    req = '0;

    // All requesters held: service order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      ops[i] = 8'($urandom);
      set_op(i, ops[i]);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, r);
      expi = k % N;
      check("t2_order", 32'(a), 32'(1 << expi));
      check("t2_result", 32'(r), 32'($countones(ops[expi])));
    end
    req = '0;

    // Late arrival on 3 is served before 1 is served again.
    do_reset();
    delay_cfg = 3;
    set_op(1, 8'h0F);
    set_op(3, 8'h07);
    req = 4'b0010;
    wait_bcs(lat);
    req = 4'b1010;
    wait_ack(a, r);
    check("t3_first", 32'(a), 32'h2);
    check("t3_first_res", 32'(r), 32'd4);
    wait_ack(a, r);
    check("t3_second", 32'(a), 32'h8);
    check("t3_second_res", 32'(r), 32'd3);
    req = '0;

    // Operand changed and request dropped while counting.
    set_op(0, 8'hF0);
    req = 4'b0001;
    wait_bcs(lat);
    set_op(0, 8'hFF);
    req = '0;
    wait_ack(a, r);
    check("t4_ack", 32'(a), 32'h1);
    check("t4_result", 32'(r), 32'd4);

    // Reset in the middle of a job, then a fresh job.
    delay_cfg = 6;
    set_op(1, 8'h7F);
    req = 4'b0010;
    wait_bcs(lat);
    @(negedge clock);
    reset = 1'b1;
    req = '0;
    @(negedge clock);
    check("t5_bc_s", 32'(bc_s), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_ack",  32'(ack),  32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    delay_cfg = 1;
    set_op(2, 8'h03);
    req = 4'b0100;
    wait_ack(a, r);
    check("t5_ack_fresh", 32'(a), 32'h4);
    check("t5_result", 32'(r), 32'd2);
    req = '0;
    repeat (4) @(negedge clock);

    // Done held 3 extra cycles after ack; zero operand.
    delay_cfg = 0;
    hold_cfg  = 3;
    set_op(0, 8'h00);
    req = 4'b0001;
    wait_ack(a, r);
    check("t6_ack", 32'(a), 32'h1);
    check("t6_result", 32'(r), 32'd0);
    hold_cfg = 0;
    wait_bcs(lat);
    check("t6_regrant_gap", 32'(lat), 32'd6);
    wait_ack(a, r);
    check("t6_ack2", 32'(a), 32'h1);
    req = '0;
    repeat (4) @(negedge clock);

    // Randomized traffic; requesters hold until their ack.
    rand_mode = 1;
    do_reset();
    pend = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if (ack[i]) begin
            pend[i] = 1'b0;
            req[i]  = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            set_op(i, 8'($urandom));
          end
        end else if ($urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          req[i]  = 1'b1;
          set_op(i, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
        end
      end
    end
    req = '0;
    repeat (30) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Watchdog in case the design never lets the bench progress.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
